// File: rtl/pic_pkg.sv
// Shared types and helpers for the parallel-indices-comparison pair reader.
package pic_pkg;

  localparam int IDX_W_DEF = 16;
  localparam int VAL_W_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } pic_state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx_a;
    logic [IDX_W_DEF-1:0] idx_b;
  } idx_pair_t;

  // Match FIFO word layout: A index in the upper half, B index in the lower half.
  function automatic idx_pair_t split_pair(input logic [2*IDX_W_DEF-1:0] word);
    idx_pair_t p;
    p.idx_a = word[2*IDX_W_DEF-1:IDX_W_DEF];
    p.idx_b = word[IDX_W_DEF-1:0];
    return p;
  endfunction

endpackage

// File: rtl/pic_lat_counter.sv
// Loadable down-counter with zero flag; times the value-memory read latency.
module pic_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pic_pair_reader.sv
// Pops matched index pairs, fetches both values and hands them downstream.
module pic_pair_reader
  import pic_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [2*IDX_W-1:0] fifo_rdata,
  input  logic               stream_done,
  output logic               mem_req,
  output logic [IDX_W-1:0]   mem_addr_a,
  output logic [IDX_W-1:0]   mem_addr_b,
  input  logic [VAL_W-1:0]   mem_rdata_a,
  input  logic [VAL_W-1:0]   mem_rdata_b,
  output logic               pair_valid,
  input  logic               pair_ready,
  output logic [IDX_W-1:0]   pair_idx_a,
  output logic [IDX_W-1:0]   pair_idx_b,
  output logic [VAL_W-1:0]   pair_val_a,
  output logic [VAL_W-1:0]   pair_val_b,
  output logic [CNT_W-1:0]   pair_count,
  output logic               row_done
);

  localparam int LAT_W = 3;

  pic_state_t       state;
  logic             done_armed;
  logic             lat_zero;
  logic [IDX_W-1:0] rd_idx_a;
  logic [IDX_W-1:0] rd_idx_b;

  if (IDX_W == IDX_W_DEF) begin : g_pkg_split
    idx_pair_t sp;
    assign sp       = split_pair(fifo_rdata);
    assign rd_idx_a = sp.idx_a;
    assign rd_idx_b = sp.idx_b;
  end else begin : g_slice_split
    assign rd_idx_a = fifo_rdata[2*IDX_W-1:IDX_W];
    assign rd_idx_b = fifo_rdata[IDX_W-1:0];
  end

  // The FIFO has a registered read, so the pop strobe must be raised in the
  // cycle that decides to pop (IDLE or an accepted HOLD) for the entry to be
  // on fifo_rdata during POP; it is therefore decoded from state, not stored.
  assign fifo_rd = !rst && !fifo_empty &&
                   ((state == S_IDLE) ||
                    ((state == S_HOLD) && pair_valid && pair_ready));

  pic_lat_counter #(
    .W (LAT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_ISSUE),
    .load_val (LAT_W'(MEM_LAT - 1)),
    .dec      (state == S_WAIT),
    .zero     (lat_zero)
  );

  // Main sequencer: pop, fetch, hold for handoff, and end-of-row reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      done_armed <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr_a <= '0;
      mem_addr_b <= '0;
      pair_valid <= 1'b0;
      pair_idx_a <= '0;
      pair_idx_b <= '0;
      pair_val_a <= '0;
      pair_val_b <= '0;
      pair_count <= '0;
      row_done   <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      row_done <= 1'b0;
      if (!stream_done) begin
        done_armed <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_POP;
          end else if (stream_done && done_armed) begin
            state      <= S_DONE;
            row_done   <= 1'b1;
            done_armed <= 1'b0;
          end
        end
        S_POP: begin
          mem_addr_a <= rd_idx_a;
          mem_addr_b <= rd_idx_b;
          pair_idx_a <= rd_idx_a;
          pair_idx_b <= rd_idx_b;
          mem_req    <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_zero) begin
            pair_val_a <= mem_rdata_a;
            pair_val_b <= mem_rdata_b;
            pair_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (pair_ready) begin
            pair_valid <= 1'b0;
            if (pair_count != '1) begin
              pair_count <= pair_count + CNT_W'(1);
            end
            state <= fifo_empty ? S_IDLE : S_POP;
          end
        end
        S_DONE: begin
          pair_count <= '0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
